// File: rtl/trap_arbiter_pkg.sv
// Shared ROB-age types, RISC-V exception codes and the ROB age comparator.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
`ifndef ROB_SIZE
`define ROB_SIZE 64
`endif

package trap_arbiter_pkg;

  // ROB depth; must be a power of two so the index wraps cleanly.
  localparam int ROB_SIZE  = `ROB_SIZE;
  localparam int ROB_IDX_W = $clog2(ROB_SIZE);
  localparam int CAUSE_W   = 16;

  // ROB index with a wrap bit that toggles each time idx wraps.
  typedef struct packed {
    logic                 flipped;
    logic [ROB_IDX_W-1:0] idx;
  } robIdx_t;

  // Synchronous exception codes reported by the writeback ports.
  typedef enum logic [CAUSE_W-1:0] {
    EXC_INST_MISALIGNED  = 16'd0,
    EXC_INST_ACCESS      = 16'd1,
    EXC_ILLEGAL_INST     = 16'd2,
    EXC_BREAKPOINT       = 16'd3,
    EXC_LOAD_MISALIGNED  = 16'd4,
    EXC_LOAD_ACCESS      = 16'd5,
    EXC_STORE_MISALIGNED = 16'd6,
    EXC_STORE_ACCESS     = 16'd7,
    EXC_ECALL_U          = 16'd8,
    EXC_ECALL_S          = 16'd9,
    EXC_ECALL_M          = 16'd11,
    EXC_INST_PAGE_FAULT  = 16'd12,
    EXC_LOAD_PAGE_FAULT  = 16'd13,
    EXC_STORE_PAGE_FAULT = 16'd15
  } rv_trap_t;

  // True when a is strictly older than b in program order. When the wrap
  // bits differ, b has wrapped past a, so a larger idx means older.
  function automatic logic rob_older(input robIdx_t a, input robIdx_t b);
    if (a.flipped == b.flipped) begin
      return a.idx < b.idx;
    end else begin
      return a.idx > b.idx;
    end
  endfunction

endpackage

// File: rtl/trap_age_select.sv
// Oldest-of-N selector: reduces N (valid, robIdx) reports with a pairwise tree.
// Latency: purely combinational.
// Backpressure: none; ties resolve to the lower port number.
module trap_age_select
  import trap_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic    [N-1:0]  vld_i,
  input  robIdx_t [N-1:0]  rob_idx_i,
  output logic             vld_o,
  output logic    [PW-1:0] port_o,
  output robIdx_t          rob_idx_o
);

  // Tree depth and width padded to a power of two; pad leaves stay invalid.
  localparam int LVLS = (N > 1) ? $clog2(N) : 0;
  localparam int P    = 1 << LVLS;

  logic          lvl_vld  [LVLS+1][P];
  logic [PW-1:0] lvl_port [LVLS+1][P];
  robIdx_t       lvl_rob  [LVLS+1][P];

  // Pairwise tournament: the right node wins only if it is valid and
  // strictly older, so equal indices keep the left (lower-numbered) port.
  always_comb begin
    for (int l = 0; l <= LVLS; l++) begin
      for (int i = 0; i < P; i++) begin
        lvl_vld[l][i]  = 1'b0;
        lvl_port[l][i] = '0;
        lvl_rob[l][i]  = '0;
      end
    end
    for (int i = 0; i < N; i++) begin
      lvl_vld[0][i]  = vld_i[i];
      lvl_port[0][i] = PW'(i);
      lvl_rob[0][i]  = rob_idx_i[i];
    end
    for (int l = 0; l < LVLS; l++) begin
      for (int i = 0; i < (P >> (l + 1)); i++) begin
        if (lvl_vld[l][2*i+1] &&
            (!lvl_vld[l][2*i] || rob_older(lvl_rob[l][2*i+1], lvl_rob[l][2*i]))) begin
          lvl_vld[l+1][i]  = 1'b1;
          lvl_port[l+1][i] = lvl_port[l][2*i+1];
          lvl_rob[l+1][i]  = lvl_rob[l][2*i+1];
        end else begin
          lvl_vld[l+1][i]  = lvl_vld[l][2*i];
          lvl_port[l+1][i] = lvl_port[l][2*i];
          lvl_rob[l+1][i]  = lvl_rob[l][2*i];
        end
      end
    end
  end

  assign vld_o     = lvl_vld[LVLS][0];
  assign port_o    = lvl_port[LVLS][0];
  assign rob_idx_o = lvl_rob[LVLS][0];

endmodule

// File: rtl/trap_arbiter.sv
// Holds the oldest pending exception and sequences stall -> CSR handshake -> flush at ROB head.
// Latency: reports visible next cycle; head match to flush pulse is 2 cycles minimum.
// Backpressure: stalls commit from head match through flush; waits on i_csr_ack without bound.
module trap_arbiter
  import trap_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int XLEN      = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic    [NUM_PORTS-1:0]              i_exc_vld,
  input  robIdx_t [NUM_PORTS-1:0]              i_exc_robIdx,
  input  logic    [NUM_PORTS-1:0][CAUSE_W-1:0] i_exc_cause,
  input  logic    [NUM_PORTS-1:0][XLEN-1:0]    i_exc_tval,
  input  logic                                 i_squash_vld,
  input  robIdx_t                              i_squash_robIdx,
  input  robIdx_t                              i_rob_head,
  input  logic                                 i_head_vld,
  input  logic                                 i_csr_ack,
  output logic                                 o_commit_stall,
  output logic                                 o_trap_vld,
  output logic    [CAUSE_W-1:0]                o_trap_cause,
  output logic    [XLEN-1:0]                   o_trap_tval,
  output robIdx_t                              o_trap_robIdx,
  output logic                                 o_flush
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HELD  = 2'd1;
  localparam logic [1:0] ST_TRAP  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               held_vld_q, held_vld_d;
  robIdx_t            held_rob_q, held_rob_d;
  logic [CAUSE_W-1:0] held_cause_q, held_cause_d;
  logic [XLEN-1:0]    held_tval_q, held_tval_d;

  logic               sel_vld;
  logic [PW-1:0]      sel_port;
  robIdx_t            sel_rob;

  logic               squash_hit;
  logic               sel_killed;
  logic               cand_vld;
  logic               kept_vld;
  logic               accepting;
  logic               head_hit;
  logic               capture;
  logic               in_trap;

  trap_age_select #(
    .N (NUM_PORTS)
  ) u_age_select (
    .vld_i     (i_exc_vld),
    .rob_idx_i (i_exc_robIdx),
    .vld_o     (sel_vld),
    .port_o    (sel_port),
    .rob_idx_o (sel_rob)
  );

  // Squash kills anything strictly younger than the mispredicting branch,
  // both the held entry and this cycle's winning report.
  assign squash_hit = i_squash_vld && held_vld_q && rob_older(i_squash_robIdx, held_rob_q);
  assign sel_killed = i_squash_vld && rob_older(i_squash_robIdx, sel_rob);
  assign cand_vld   = sel_vld && !sel_killed;
  assign kept_vld   = held_vld_q && !squash_hit;

  // Only IDLE/HELD track reports; once trapping the entry is architectural.
  assign accepting  = (state_q == ST_IDLE) || (state_q == ST_HELD);

  // The held instruction reaching the head takes priority over any capture;
  // nothing valid can be older than the ROB head anyway.
  assign head_hit   = (state_q == ST_HELD) && kept_vld && i_head_vld &&
                      (i_rob_head == held_rob_q);
  assign capture    = accepting && !head_hit && cand_vld &&
                      (!kept_vld || rob_older(sel_rob, held_rob_q));

  // Next-state and held-entry update: squash first, then capture, then FSM.
  always_comb begin
    state_d      = state_q;
    held_vld_d   = held_vld_q;
    held_rob_d   = held_rob_q;
    held_cause_d = held_cause_q;
    held_tval_d  = held_tval_q;

    if (accepting) begin
      held_vld_d = kept_vld;
    end
    if (capture) begin
      held_vld_d   = 1'b1;
      held_rob_d   = sel_rob;
      held_cause_d = i_exc_cause[sel_port];
      held_tval_d  = i_exc_tval[sel_port];
    end

    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (head_hit) begin
          state_d = ST_TRAP;
        end else if (!capture && !kept_vld) begin
          state_d = ST_IDLE;
        end
      end
      ST_TRAP: begin
        if (i_csr_ack) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_d      = ST_IDLE;
        held_vld_d   = 1'b0;
        held_rob_d   = '0;
        held_cause_d = '0;
        held_tval_d  = '0;
      end
      default: begin
        state_d    = ST_IDLE;
        held_vld_d = 1'b0;
      end
    endcase
  end

  // State and held entry; reset aborts any in-flight trap without a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      held_vld_q   <= 1'b0;
      held_rob_q   <= '0;
      held_cause_q <= '0;
      held_tval_q  <= '0;
    end else begin
      state_q      <= state_d;
      held_vld_q   <= held_vld_d;
      held_rob_q   <= held_rob_d;
      held_cause_q <= held_cause_d;
      held_tval_q  <= held_tval_d;
    end
  end

  // Trap fields come straight from the held registers, zeroed outside TRAP.
  assign in_trap        = (state_q == ST_TRAP);
  assign o_trap_vld     = in_trap;
  assign o_trap_cause   = in_trap ? held_cause_q : '0;
  assign o_trap_tval    = in_trap ? held_tval_q  : '0;
  assign o_trap_robIdx  = in_trap ? held_rob_q   : '0;
  assign o_flush        = (state_q == ST_FLUSH);
  assign o_commit_stall = head_hit || in_trap || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_trap_arbiter.sv
// Bench for trap_arbiter: directed scenarios plus randomized traffic against a sequence-number model.
// Latency: checks sampled on the falling edge; stimulus driven 1 time unit after the rising edge.
// Backpressure: random head advance honours o_commit_stall; CSR ack is random.
module tb_trap_arbiter;
  import trap_arbiter_pkg::*;

  localparam int NP   = 4;
  localparam int XL   = 64;
  localparam int RS   = ROB_SIZE;
  localparam int SEQN = 2 * ROB_SIZE;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic    [NP-1:0]         exc_vld;
  robIdx_t [NP-1:0]         exc_rob;
  logic    [NP-1:0][15:0]   exc_cause;
  logic    [NP-1:0][XL-1:0] exc_tval;
  logic                     squash_vld;
  robIdx_t                  squash_rob;
  robIdx_t                  rob_head;
  logic                     head_vld;
  logic                     csr_ack;
  logic                     o_commit_stall;
  logic                     o_trap_vld;
  logic    [15:0]           o_trap_cause;
  logic    [XL-1:0]         o_trap_tval;
  robIdx_t                  o_trap_robIdx;
  logic                     o_flush;

  int checks = 0;
  int errors = 0;

  trap_arbiter #(.NUM_PORTS(NP), .XLEN(XL)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_exc_vld       (exc_vld),
    .i_exc_robIdx    (exc_rob),
    .i_exc_cause     (exc_cause),
    .i_exc_tval      (exc_tval),
    .i_squash_vld    (squash_vld),
    .i_squash_robIdx (squash_rob),
    .i_rob_head      (rob_head),
    .i_head_vld      (head_vld),
    .i_csr_ack       (csr_ack),
    .o_commit_stall  (o_commit_stall),
    .o_trap_vld      (o_trap_vld),
    .o_trap_cause    (o_trap_cause),
    .o_trap_tval     (o_trap_tval),
    .o_trap_robIdx   (o_trap_robIdx),
    .o_flush         (o_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: ROB positions as plain sequence numbers
  function automatic int sq(input robIdx_t r);
    return int'({r.flipped, r.idx});
  endfunction

  function automatic robIdx_t to_rob(input int s);
    logic [ROB_IDX_W:0] v;
    v = s[ROB_IDX_W:0];
    return robIdx_t'(v);
  endfunction

  // a is older than b when b lies 1..RS-1 steps after a around the 2*RS ring.
  function automatic bit older(input int a, input int b);
    int d;
    d = (b - a + SEQN) % SEQN;
    return (d != 0) && (d < RS);
  endfunction

  typedef struct {
    int          rob;
    logic [15:0] cause;
    logic [63:0] tval;
  } exp_t;

  exp_t        trap_q[$];
  exp_t        cur;
  int          m_phase = 0;   // 0 nothing, 1 tracking, 2 trapping, 3 flushing
  bit          m_vld   = 1'b0;
  int          m_seq   = 0;
  logic [15:0] m_cause = '0;
  logic [63:0] m_tval  = '0;

  function automatic bit m_killed(input int s);
    return squash_vld && older(sq(squash_rob), s);
  endfunction

  function automatic bit m_head_hit();
    return (m_phase == 1) && m_vld && head_vld && (sq(rob_head) == m_seq) && !m_killed(m_seq);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_vld   = 1'b0;
      trap_q.delete();
    end else if (m_phase == 2) begin
      if (csr_ack) m_phase = 3;
    end else if (m_phase == 3) begin
      m_phase = 0;
      m_vld   = 1'b0;
    end else if (m_head_hit()) begin
      m_phase = 2;
      trap_q.push_back('{rob: m_seq, cause: m_cause, tval: m_tval});
    end else begin : m_track
      int best;
      best = -1;
      if (m_vld && m_killed(m_seq)) m_vld = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (exc_vld[p] && !m_killed(sq(exc_rob[p])) &&
            (best < 0 || older(sq(exc_rob[p]), sq(exc_rob[best])))) best = p;
      end
      if (best >= 0 && (!m_vld || older(sq(exc_rob[best]), m_seq))) begin
        m_vld   = 1'b1;
        m_seq   = sq(exc_rob[best]);
        m_cause = exc_cause[best];
        m_tval  = exc_tval[best];
      end
      m_phase = m_vld ? 1 : 0;
    end
  end

  // ---------------- monitor / scoreboard
  bit mon_prev_trap = 1'b0;
  bit mon_commit    = 1'b0;
  bit mon_flush     = 1'b0;

  always @(negedge clk) begin
    chk("commit_stall", 64'(o_commit_stall), 64'(m_head_hit() || (m_phase >= 2)));
    chk("trap_vld", 64'(o_trap_vld), 64'(m_phase == 2));
    chk("flush", 64'(o_flush), 64'(m_phase == 3));
    if (o_trap_vld && !mon_prev_trap) begin
      chk("trap_expected", 64'(trap_q.size() != 0), 64'd1);
      if (trap_q.size() != 0) cur = trap_q.pop_front();
    end
    if (o_trap_vld) begin
      chk("trap_cause", 64'(o_trap_cause), 64'(cur.cause));
      chk("trap_tval", o_trap_tval, cur.tval);
      chk("trap_rob", 64'(sq(o_trap_robIdx)), 64'(cur.rob));
    end else begin
      chk("trap_fields_zero",
          64'((o_trap_cause != 0) || (o_trap_tval != 0) || (o_trap_robIdx != 0)), 64'd0);
    end
    mon_prev_trap = o_trap_vld;
    mon_commit    = head_vld && !o_commit_stall;
    mon_flush     = o_flush;
  end

  // ---------------- driver helpers
  task automatic clear_inputs();
    exc_vld    = '0;
    exc_rob    = '0;
    exc_cause  = '0;
    exc_tval   = '0;
    squash_vld = 1'b0;
    squash_rob = '0;
    rob_head   = '0;
    head_vld   = 1'b0;
    csr_ack    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic set_rep(input int p, input int s, input logic [15:0] c, input logic [63:0] t);
    exc_vld[p]   = 1'b1;
    exc_rob[p]   = to_rob(s);
    exc_cause[p] = c;
    exc_tval[p]  = t;
  endtask

  task automatic report1(input int p, input int s, input logic [15:0] c, input logic [63:0] t);
    set_rep(p, s, c, t);
    step();
    clear_inputs();
  endtask

  // Present head = h, expect a trap carrying (c, t), optionally wait and
  // inject an older report plus a squash while trapping, then ack and flush.
  task automatic trap_seq(input int h, input logic [15:0] c, input logic [63:0] t,
                          input int wait_cycles, input bit inject);
    rob_head = to_rob(h);
    head_vld = 1'b1;
    #1 chk("head_stall_comb", 64'(o_commit_stall), 64'd1);
    step();
    clear_inputs();
    for (int i = 0; i < wait_cycles; i++) begin
      if (inject) begin
        set_rep(0, (h + SEQN - 5) % SEQN, 16'h0099, 64'hbad);
        squash_vld = 1'b1;
        squash_rob = to_rob((h + SEQN - 17) % SEQN);
      end
      #1;
      chk("wait_trap_vld", 64'(o_trap_vld), 64'd1);
      chk("wait_stall", 64'(o_commit_stall), 64'd1);
      chk("wait_cause", 64'(o_trap_cause), 64'(c));
      step();
      clear_inputs();
    end
    #1;
    chk("trap_vld_dir", 64'(o_trap_vld), 64'd1);
    chk("trap_cause_dir", 64'(o_trap_cause), 64'(c));
    chk("trap_tval_dir", o_trap_tval, t);
    chk("trap_rob_dir", 64'(sq(o_trap_robIdx)), 64'(h));
    csr_ack = 1'b1;
    step();
    csr_ack = 1'b0;
    #1;
    chk("flush_pulse", 64'(o_flush), 64'd1);
    chk("flush_stall", 64'(o_commit_stall), 64'd1);
    step();
    #1;
    chk("flush_single", 64'(o_flush), 64'd0);
    chk("post_flush_stall", 64'(o_commit_stall), 64'd0);
    chk("post_flush_trap", 64'(o_trap_vld), 64'd0);
  endtask

  bit mark[SEQN];
  int hs;

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", 64'(o_commit_stall), 64'd0);
    chk("reset_trap_vld", 64'(o_trap_vld), 64'd0);
    chk("reset_flush", 64'(o_flush), 64'd0);
    chk("reset_fields", 64'((o_trap_cause != 0) || (o_trap_tval != 0) || (o_trap_robIdx != 0)), 64'd0);
    rst_n = 1'b1;
    step();

    // Single report, then head match and ack on the first trap cycle.
    report1(1, 5, 16'd2, 64'hdead);
    step();
    trap_seq(5, 16'd2, 64'hdead, 0, 1'b0);

    // Wrap: {f0,60} beats {f1,2}; a later {f1,1} does not replace it.
    do_reset();
    set_rep(0, 66, 16'h0010, 64'h11);
    set_rep(3, 60, 16'h0013, 64'h33);
    step();
    clear_inputs();
    report1(1, 65, 16'h0021, 64'h21);
    trap_seq(60, 16'h0013, 64'h33, 0, 1'b0);

    // Wrap again, but {f0,59} is strictly older and replaces the entry.
    do_reset();
    set_rep(0, 66, 16'h0010, 64'h11);
    set_rep(3, 60, 16'h0013, 64'h33);
    step();
    clear_inputs();
    report1(2, 59, 16'h0022, 64'h59);
    trap_seq(59, 16'h0022, 64'h59, 0, 1'b0);

    // Tie on idx 7: the lower port wins.
    do_reset();
    set_rep(1, 7, 16'h0031, 64'h3131);
    set_rep(2, 7, 16'h0032, 64'h3232);
    step();
    clear_inputs();
    trap_seq(7, 16'h0031, 64'h3131, 0, 1'b0);

    // Squash older than the held entry drops it; head match then does nothing.
    do_reset();
    report1(0, 10, 16'h0040, 64'h40);
    squash_vld = 1'b1;
    squash_rob = to_rob(8);
    step();
    clear_inputs();
    rob_head = to_rob(10);
    head_vld = 1'b1;
    #1 chk("squashed_no_stall", 64'(o_commit_stall), 64'd0);
    step();
    #1 chk("squashed_no_trap", 64'(o_trap_vld), 64'd0);
    clear_inputs();

    // Squash younger than the held entry keeps it.
    do_reset();
    report1(0, 10, 16'h0041, 64'h41);
    squash_vld = 1'b1;
    squash_rob = to_rob(12);
    step();
    clear_inputs();
    trap_seq(10, 16'h0041, 64'h41, 0, 1'b0);

    // Older report and squash while trapping are ignored.
    do_reset();
    report1(1, 20, 16'h0050, 64'h5050);
    trap_seq(20, 16'h0050, 64'h5050, 3, 1'b1);

    // Ack withheld for 20 cycles.
    report1(2, 30, 16'h0060, 64'h6060);
    trap_seq(30, 16'h0060, 64'h6060, 20, 1'b0);

    // Reset mid-trap: outputs drop immediately and no flush follows.
    report1(3, 40, 16'h0070, 64'h7070);
    rob_head = to_rob(40);
    head_vld = 1'b1;
    step();
    clear_inputs();
    #1 chk("pre_reset_trap", 64'(o_trap_vld), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_stall", 64'(o_commit_stall), 64'd0);
    chk("arst_trap_vld", 64'(o_trap_vld), 64'd0);
    chk("arst_fields", 64'((o_trap_cause != 0) || (o_trap_tval != 0) || (o_trap_robIdx != 0)), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      #1 chk("arst_no_flush", 64'(o_flush), 64'd0);
    end

    // Randomized traffic in a 31-entry window above the ROB head.
    do_reset();
    hs = 0;
    for (int i = 0; i < SEQN; i++) mark[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (mon_flush) begin
        for (int i = 0; i < SEQN; i++) mark[i] = 1'b0;
        hs = (hs + 1) % SEQN;
      end else if (mon_commit && !mark[hs]) begin
        hs = (hs + 1) % SEQN;
      end
      rob_head   = to_rob(hs);
      head_vld   = ($urandom_range(0, 3) != 0);
      csr_ack    = ($urandom_range(0, 3) == 0);
      squash_vld = ($urandom_range(0, 15) == 0);
      squash_rob = to_rob((hs + $urandom_range(0, 30)) % SEQN);
      for (int p = 0; p < NP; p++) begin
        int s;
        s = (hs + $urandom_range(0, 30)) % SEQN;
        exc_vld[p]   = ($urandom_range(0, 7) == 0);
        exc_rob[p]   = to_rob(s);
        exc_cause[p] = 16'($urandom_range(0, 65535));
        exc_tval[p]  = {$urandom, $urandom};
        if (exc_vld[p] && !m_killed(s)) mark[s] = 1'b1;
      end
      if (squash_vld) begin
        for (int k = 0; k <= 30; k++) begin
          if (older(sq(squash_rob), (hs + k) % SEQN)) mark[(hs + k) % SEQN] = 1'b0;
        end
      end
      step();
    end

    // Drain any trap in flight.
    clear_inputs();
    csr_ack = 1'b1;
    repeat (10) step();
    chk("trap_q_drained", 64'(trap_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
